// File: rtl/lvg_agg_pkg.sv
// Shared types and wavefront geometry helpers for the LVG skew aggregator.
// Optional feature macro used by this slice: SKEW_AGG_ACCUM_EN.
package lvg_agg_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } agg_state_t;

    // Number of anti-diagonal wavefronts in an n x n tile.
    function automatic int waves(input int n);
        return 2 * n - 1;
    endfunction

    // Number of meaningful lanes on wavefront k.
    function automatic int diag_len(input int k, input int n);
        return (k + 1 < 2 * n - 1 - k) ? k + 1 : 2 * n - 1 - k;
    endfunction

    // Row carried by lane j of wavefront k.
    function automatic int diag_row(input int k, input int j, input int n);
        return j + ((k > n - 1) ? k - (n - 1) : 0);
    endfunction

endpackage

// File: rtl/agg_cell.sv
// One tile element register with write enable and optional accumulate.
// The adder exists only when SKEW_AGG_ACCUM_EN is defined.
module agg_cell
    import lvg_agg_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_acc,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

`ifdef SKEW_AGG_ACCUM_EN
    // Overwrite or wrap-around accumulate on write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_acc ? r_q + i_d : i_d;
        end
    end
`else
    logic w_unused_acc;
    assign w_unused_acc = i_acc;

    // Plain overwrite on write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end
`endif

    assign o_q = r_q;

endmodule

// File: rtl/skew_aggregator.sv
// De-skews N-lane anti-diagonal wavefronts into a registered N x N tile.
// Optional in-place accumulation is enabled by SKEW_AGG_ACCUM_EN.
module skew_aggregator
    import lvg_agg_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*DATA_W-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_accum,
    input  logic                  clear,
    output logic [N*N*DATA_W-1:0] out_mat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int WAVES = waves(N);
    localparam int WV_W  = $clog2(WAVES);

    agg_state_t      r_state;
    logic [WV_W-1:0] r_wv;
    logic            r_out_valid;
    logic            r_busy;
    logic            w_accept;
    logic            w_last;
    logic            w_acc_sel;

    assign in_ready = (r_state == COLLECT) ||
                      (r_state == FULL && out_ready);
    assign w_accept = in_valid && in_ready && !clear;
    assign w_last   = (r_wv == WV_W'(WAVES - 1));

    // Wave counter and COLLECT/FULL sequencing; clear aborts the tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_wv        <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (clear) begin
            r_state     <= COLLECT;
            r_wv        <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                COLLECT: begin
                    if (in_valid) begin
                        if (w_last) begin
                            r_state     <= FULL;
                            r_wv        <= '0;
                            r_out_valid <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_wv   <= r_wv + WV_W'(1);
                            r_busy <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        r_state     <= COLLECT;
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_wv   <= WV_W'(1);
                            r_busy <= 1'b1;
                        end
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

`ifdef SKEW_AGG_ACCUM_EN
    logic r_accum;

    // Latch the accumulate mode with wavefront 0 for the rest of the tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_accum <= 1'b0;
        end else if (w_accept && r_wv == '0) begin
            r_accum <= in_accum;
        end
    end

    assign w_acc_sel = (r_wv == '0) ? in_accum : r_accum;
`else
    logic w_unused_accum;
    assign w_unused_accum = in_accum;
    assign w_acc_sel      = 1'b0;
`endif

    // Cell (r,c) sits on diagonal r+c and is fed by the lane carrying row r.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            localparam int K = r + c;
            localparam int J = r - diag_row(K, 0, N);
            logic w_we;
            assign w_we = w_accept && (r_wv == WV_W'(K));
            agg_cell #(
                .DATA_W (DATA_W)
            ) u_cell (
                .clk   (clk),
                .rst   (rst),
                .i_we  (w_we),
                .i_acc (w_acc_sel),
                .i_d   (in_data[J*DATA_W +: DATA_W]),
                .o_q   (out_mat[(r*N+c)*DATA_W +: DATA_W])
            );
        end
    end

    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_skew_aggregator.sv
// Self-checking bench for skew_aggregator (N=4, DATA_W=32).
// Tile scoreboard plus table-driven tiles and hand-written corner sequences.
module tb_skew_aggregator;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int WAVES = 2 * N - 1;
`ifdef SKEW_AGG_ACCUM_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_accum;
    logic              clear;
    logic [N*N*DW-1:0] out_mat;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    always #5 clk = ~clk;

    skew_aggregator #(.N(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_accum  (in_accum),
        .clear     (clear),
        .out_mat   (out_mat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]     m [N*N];
    bit                m_acc;
    logic [N*N*DW-1:0] sbq [$];

    typedef struct {
        int          p;
        logic [31:0] v;
        bit          gaps;
        bit          garb;
        logic [31:0] exp00;
        logic [31:0] exp33;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_mat(string name, logic [N*N*DW-1:0] act,
                           logic [N*N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N*N*DW-1:0] flat();
        logic [N*N*DW-1:0] f;
        for (int i = 0; i < N * N; i++) f[i*DW +: DW] = m[i];
        return f;
    endfunction

    function automatic int lanes(int k);
        return (k < N) ? k + 1 : 2 * N - 1 - k;
    endfunction

    function automatic int row0(int k);
        return (k >= N) ? k - N + 1 : 0;
    endfunction

    function automatic logic [DW-1:0] pat(int p, logic [DW-1:0] v,
                                          int r, int c);
        return (p == 0) ? DW'(r * N + c) : v;
    endfunction

    task automatic set_wave(int k, int p, logic [DW-1:0] v, bit garb);
        for (int j = 0; j < N; j++) begin
            if (j < lanes(k))
                in_data[j*DW +: DW] = pat(p, v, j + row0(k), k - j - row0(k));
            else
                in_data[j*DW +: DW] = garb ? 32'hDEADBEEF : 32'h0;
        end
    endtask

    task automatic model_accept(int k, logic [N*DW-1:0] d, bit acc);
        int r;
        int c;
        logic [DW-1:0] v;
        if (k == 0) m_acc = acc;
        for (int j = 0; j < lanes(k); j++) begin
            r = j + row0(k);
            c = k - r;
            v = d[j*DW +: DW];
            m[r*N+c] = (ACC && m_acc) ? m[r*N+c] + v : v;
        end
        if (k == WAVES - 1) sbq.push_back(flat());
    endtask

    task automatic drive(int k, int p, logic [DW-1:0] v, bit garb, bit acc);
        bit ok;
        bit rdy;
        ok = 1'b0;
        set_wave(k, p, v, garb);
        in_valid = 1'b1;
        in_accum = acc;
        for (int t = 0; t < 30 && !ok; t++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                model_accept(k, in_data, acc);
            end
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: wave %0d got no accept, need accept", k);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_tile(int p, logic [DW-1:0] v, bit gaps, bit garb,
                             bit acc);
        for (int k = 0; k < WAVES; k++) begin
            if (gaps && k > 0) begin
                in_valid = 1'b0;
                in_data  = {N{32'hDEADBEEF}};
                @(posedge clk);
                #1;
                chk("gap_wv", 64'(dut.r_wv), 64'(k));
            end
            drive(k, p, v, garb, acc);
        end
    endtask

    // Scoreboard: pop and compare every tile the consumer takes.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got tile, expected none");
            end else begin
                chk_mat("sb_tile", out_mat, sbq.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*N*DW-1:0] snap;
        bit                allok;
        logic [DW-1:0]     want;

        tbl[0] = '{0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hF};
        tbl[1] = '{0, 32'h0,        1'b1, 1'b1, 32'h0,        32'hF};
        tbl[2] = '{1, 32'h11,       1'b0, 1'b1, 32'h11,       32'h11};
        tbl[3] = '{1, 32'hA5A55A5A, 1'b1, 1'b0, 32'hA5A55A5A, 32'hA5A55A5A};

        for (int i = 0; i < N * N; i++) m[i] = '0;
        m_acc     = 1'b0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_accum  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk_mat("rst_out_mat", out_mat, '0);
        @(posedge clk);
        #1;

        // Latency: out_valid visible right after the wave-6 accept edge.
        for (int k = 0; k < WAVES; k++) begin
            drive(k, 0, 32'h0, 1'b0, 1'b0);
            if (k == 0) chk("lat_busy_w0", 64'(busy), 64'(1));
            if (k == WAVES - 2) chk("lat_valid_w5", 64'(out_valid), 64'(0));
        end
        chk("lat_valid_w6", 64'(out_valid), 64'(1));
        chk("lat_busy_w6", 64'(busy), 64'(0));
        idle(1);
        chk("lat_pulse", 64'(out_valid), 64'(0));

        for (int i = 0; i < 4; i++) begin
            send_tile(tbl[i].p, tbl[i].v, tbl[i].gaps, tbl[i].garb, 1'b0);
            chk("tbl_valid", 64'(out_valid), 64'(1));
            chk("tbl_c00", 64'(out_mat[0 +: DW]), 64'(tbl[i].exp00));
            chk("tbl_c33", 64'(out_mat[15*DW +: DW]), 64'(tbl[i].exp33));
            idle(1);
            chk("tbl_drop", 64'(out_valid), 64'(0));
        end

        // Back-pressure, then wave 0 taken as the tile leaves.
        out_ready = 1'b0;
        send_tile(1, 32'h77, 1'b0, 1'b0, 1'b0);
        snap = flat();
        set_wave(0, 1, 32'h33, 1'b0);
        in_valid = 1'b1;
        in_accum = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk_mat("bp_stable", out_mat, snap);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        model_accept(0, in_data, 1'b0);
        #1;
        in_valid = 1'b0;
        chk("bp_busy", 64'(busy), 64'(1));
        chk("bp_valid_drop", 64'(out_valid), 64'(0));
        chk("bp_wv", 64'(dut.r_wv), 64'(1));
        for (int k = 1; k < WAVES; k++) drive(k, 1, 32'h33, 1'b0, 1'b0);
        idle(1);

        // Abort at wv=3, then a clean tile of 0x11.
        for (int k = 0; k < 3; k++) drive(k, 1, 32'h55, 1'b0, 1'b0);
        chk("clr_pre_busy", 64'(busy), 64'(1));
        set_wave(3, 1, 32'h55, 1'b0);
        in_valid = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_busy", 64'(busy), 64'(0));
        chk("clr_valid", 64'(out_valid), 64'(0));
        chk("clr_wv", 64'(dut.r_wv), 64'(0));
        send_tile(1, 32'h11, 1'b0, 1'b0, 1'b0);
        allok = 1'b1;
        for (int i = 0; i < N * N; i++)
            if (out_mat[i*DW +: DW] !== 32'h11) allok = 1'b0;
        chk("clr_cells", 64'(allok), 64'(1));
        idle(1);

        // Asynchronous reset between edges at wv=5.
        for (int k = 0; k < 5; k++) drive(k, 1, 32'h66, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk_mat("arst_mat", out_mat, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N * N; i++) m[i] = '0;
        sbq.delete();
        idle(1);

        // Accumulate: 0xFFFFFFFF then 2 with in_accum.
        send_tile(1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        idle(1);
        send_tile(1, 32'h2, 1'b0, 1'b0, 1'b1);
        want  = ACC ? 32'h1 : 32'h2;
        allok = 1'b1;
        for (int i = 0; i < N * N; i++)
            if (out_mat[i*DW +: DW] !== want) allok = 1'b0;
        chk("acc_cells", 64'(allok), 64'(1));
        idle(2);

        chk("sb_empty", 64'(sbq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
